// File: rtl/uart_tx_if.sv
// uart_tx_if: configuration, byte handshake and serial line between the
// register block (master) and the transmit serializer (slave).
interface uart_tx_if;
    logic       utrst;
    logic [7:0] dll;
    logic [7:0] dlh;
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] thr_data;
    logic       thr_valid;
    logic       tsr_load;
    logic       shift_cnt_eq;
    logic       tx_busy;
    logic       txd;
    modport master (
        output utrst, dll, dlh, wls, stb, pen, eps, sp, thr_data, thr_valid,
        input  tsr_load, shift_cnt_eq, tx_busy, txd
    );
    modport slave (
        input  utrst, dll, dlh, wls, stb, pen, eps, sp, thr_data, thr_valid,
        output tsr_load, shift_cnt_eq, tx_busy, txd
    );
endinterface

// File: rtl/uart_tx.sv
// uart_tx: UART transmit serializer with divisor baud timing, 5-8 data bits,
// optional parity and 1/1.5/2 stop bits; reports load and frame-end pulses.
module uart_tx #(
    parameter int OSR = 16
) (
    input  logic     pclk,
    input  logic     presetn,
    uart_tx_if.slave tx
);
    localparam int TW = $clog2(2 * OSR);
    localparam logic [TW-1:0] T1  = TW'(OSR - 1);
    localparam logic [TW-1:0] T15 = TW'(3 * OSR / 2 - 1);
    localparam logic [TW-1:0] T2  = TW'(2 * OSR - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
    state_e        state_q, state_d;
    logic [15:0]   div, baud_q, baud_d;
    logic [TW-1:0] tick_q, tick_d, tick_last;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tsr_q, tsr_d, mask;
    logic [1:0]    wls_q, wls_d;
    logic          stb_q, stb_d, pen_q, pen_d, par_q, par_d, txd_q, txd_d;
    logic          tick, bit_end, last_stop, load;
    assign div       = {tx.dlh, tx.dll};
    assign tick      = state_q != IDLE && div != 16'd0 && baud_q >= div - 16'd1;
    assign tick_last = state_q != STOP ? T1 : !stb_q ? T1 : wls_q == 2'b00 ? T15 : T2;
    assign bit_end   = tick && tick_q == tick_last;
    assign last_stop = state_q == STOP && bit_end;
    assign load      = presetn && tx.utrst && tx.thr_valid && div != 16'd0 &&
                       (state_q == IDLE || last_stop);
    assign mask      = 8'hFF >> (3'd3 - {1'b0, tx.wls});
    assign tx.tsr_load     = load;
    assign tx.shift_cnt_eq = tx.utrst && last_stop;
    assign tx.tx_busy      = state_q != IDLE;
    assign tx.txd          = txd_q;
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || tick) ? '0 : baud_q + 16'd1;
        tick_d  = (state_q == IDLE || bit_end) ? '0 : tick_q + TW'(tick);
        bit_d   = bit_q;
        tsr_d   = tsr_q;
        wls_d   = wls_q;
        stb_d   = stb_q;
        pen_d   = pen_q;
        par_d   = par_q;
        txd_d   = txd_q;
        if (bit_end) begin
            case (state_q)
                START: begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = tsr_q[0];
                end
                DATA: begin
                    tsr_d = tsr_q >> 1;
                    bit_d = bit_q + 3'd1;
                    txd_d = tsr_q[1];
                    if (bit_q == {1'b0, wls_q} + 3'd4) begin
                        state_d = pen_q ? PARITY : STOP;
                        txd_d   = pen_q ? par_q : 1'b1;
                    end
                end
                PARITY: begin
                    state_d = STOP;
                    txd_d   = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end
        // parity is fixed at load time so later register writes cannot disturb it
        if (load) begin
            state_d = START;
            baud_d  = '0;
            tick_d  = '0;
            bit_d   = '0;
            tsr_d   = tx.thr_data;
            wls_d   = tx.wls;
            stb_d   = tx.stb;
            pen_d   = tx.pen;
            par_d   = tx.sp ? ~tx.eps : ^(tx.thr_data & mask) ^ ~tx.eps;
            txd_d   = 1'b0;
        end
        if (!tx.utrst) begin
            state_d = IDLE;
            baud_d  = '0;
            tick_d  = '0;
            bit_d   = '0;
            txd_d   = 1'b1;
        end
    end
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            tsr_q   <= '0;
            wls_q   <= '0;
            stb_q   <= 1'b0;
            pen_q   <= 1'b0;
            par_q   <= 1'b0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            tsr_q   <= tsr_d;
            wls_q   <= wls_d;
            stb_q   <= stb_d;
            pen_q   <= pen_d;
            par_q   <= par_d;
            txd_q   <= txd_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven frame checks against a bit-level frame model,
// plus back-to-back, abort, zero-divisor and async-reset sequences.
module tb_uart_tx;
    localparam int OSR = 16;
    logic pclk = 1'b0;
    logic presetn;
    int   n_cmp = 0;
    int   n_bad = 0;
    uart_tx_if bus();
    uart_tx #(.OSR(OSR)) dut (.pclk(pclk), .presetn(presetn), .tx(bus));
    always #5 pclk = ~pclk;
    typedef struct {
        logic [15:0] d;
        logic [1:0]  wls;
        logic        stb, pen, eps, sp;
        logic [7:0]  data;
        logic        par;
        int          stop_cyc;
    } vec_t;
    typedef struct {
        logic [11:0] bits;
        int          n;
        int          bitlen;
        int          stop;
    } frame_t;
    vec_t   vecs[8];
    frame_t sb[$];
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask
    function automatic frame_t mk(input vec_t v);
        frame_t f;
        int nb = 5 + int'(v.wls);
        f.bits = '0;
        for (int i = 0; i < nb; i++) f.bits[1+i] = v.data[i];
        f.n = 1 + nb;
        if (v.pen) begin
            f.bits[f.n] = v.par;
            f.n++;
        end
        f.bitlen = int'(v.d) * OSR;
        f.stop   = v.stop_cyc;
        return f;
    endfunction
    task automatic drive_load(input vec_t v, input bit push);
        @(posedge pclk); #1;
        bus.dll = v.d[7:0];
        bus.dlh = v.d[15:8];
        bus.wls = v.wls;
        bus.stb = v.stb;
        bus.pen = v.pen;
        bus.eps = v.eps;
        bus.sp = v.sp;
        bus.thr_data = v.data;
        bus.thr_valid = 1'b1;
        if (push) sb.push_back(mk(v));
        @(negedge pclk);
        chk("tsr_load", {31'd0, bus.tsr_load}, 32'd1);
    endtask
    task automatic check_frame(input int id, input logic valid_after, input logic [7:0] next_data,
                               input logic load_at_end);
        frame_t f;
        int cyc = 0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        f = sb.pop_front();
        for (int b = 0; b <= f.n; b++) begin
            int   len = (b == f.n) ? f.stop : f.bitlen;
            logic e = (b == f.n) ? 1'b1 : f.bits[b];
            logic ok = 1'b1;
            logic [3:0] got = '0;
            int   bad_cyc = 0;
            for (int k = 0; k < len; k++) begin
                logic last;
                @(negedge pclk);
                cyc++;
                last = (b == f.n) && (k == len - 1);
                if (ok && (bus.txd !== e || bus.tx_busy !== 1'b1 || bus.shift_cnt_eq !== last ||
                           bus.tsr_load !== (last && load_at_end))) begin
                    ok = 1'b0;
                    got = {bus.txd, bus.tx_busy, bus.shift_cnt_eq, bus.tsr_load};
                    bad_cyc = cyc;
                end
                if (cyc == 1) begin
                    bus.thr_valid = valid_after;
                    bus.thr_data = next_data;
                    if (!valid_after) begin
                        bus.wls = ~bus.wls;
                        bus.pen = ~bus.pen;
                        bus.stb = ~bus.stb;
                        bus.eps = ~bus.eps;
                        bus.sp = ~bus.sp;
                    end
                end
            end
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL frame%0d bit%0d: {txd,busy,sce,load}=%b at cycle %0d, required txd=%b busy=1",
                         id, b, got, bad_cyc, e);
            end
        end
    endtask
    task automatic check_idle(input string nm);
        @(negedge pclk);
        chk(nm, {30'd0, bus.txd, bus.tx_busy}, 32'b10);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic bad;
        vec_t v1, v2;
        vecs[0] = '{16'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 16};
        vecs[1] = '{16'd3, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 8'h35, 1'b0, 48};
        vecs[2] = '{16'd3, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 8'h35, 1'b1, 48};
        vecs[3] = '{16'd1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 16};
        vecs[4] = '{16'd1, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 16};
        vecs[5] = '{16'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 24};
        vecs[6] = '{16'd1, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 8'h1F, 1'b0, 32};
        vecs[7] = '{16'd2, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 8'h2B, 1'b1, 32};
        presetn = 1'b0;
        bus.utrst = 1'b1;
        bus.dll = 8'd1;
        bus.dlh = 8'd0;
        bus.wls = 2'b11;
        bus.stb = 1'b0;
        bus.pen = 1'b0;
        bus.eps = 1'b0;
        bus.sp = 1'b0;
        bus.thr_data = 8'h00;
        bus.thr_valid = 1'b1;
        repeat (2) @(negedge pclk);
        chk("reset_outputs", {28'd0, bus.txd, bus.tx_busy, bus.tsr_load, bus.shift_cnt_eq}, 32'b1000);
        bus.thr_valid = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        check_idle("idle_after_reset");
        for (int i = 0; i < 8; i++) begin
            drive_load(vecs[i], 1'b1);
            check_frame(i, 1'b0, 8'h00, 1'b0);
            check_idle("idle_after_frame");
        end
        v1 = '{16'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 32};
        v2 = '{16'd2, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 32};
        drive_load(v1, 1'b1);
        sb.push_back(mk(v2));
        check_frame(10, 1'b1, 8'hAA, 1'b1);
        check_frame(11, 1'b0, 8'h00, 1'b0);
        check_idle("idle_after_b2b");
        drive_load(vecs[0], 1'b0);
        for (int c = 1; c <= 69; c++) begin
            @(negedge pclk);
            if (c == 1) bus.thr_valid = 1'b0;
        end
        chk("abort_pre_txd", {31'd0, bus.txd}, 32'd0);
        bus.utrst = 1'b0;
        bus.thr_valid = 1'b1;
        check_idle("abort_txd_busy");
        bad = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge pclk);
            if (bus.tsr_load || bus.shift_cnt_eq || !bus.txd || bus.tx_busy) bad = 1'b1;
            if (c == 20) bus.thr_valid = 1'b0;
            if (c == 21) bus.utrst = 1'b1;
        end
        chk("abort_quiet", {31'd0, bad}, 32'd0);
        @(posedge pclk); #1;
        bus.dll = 8'd0;
        bus.dlh = 8'd0;
        bus.thr_valid = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge pclk);
            if (bus.tsr_load || !bus.txd || bus.tx_busy) bad = 1'b1;
        end
        chk("d0_no_load", {31'd0, bad}, 32'd0);
        bus.thr_valid = 1'b0;
        drive_load(vecs[0], 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge pclk);
            if (c == 1) bus.thr_valid = 1'b0;
        end
        chk("rst_pre_busy", {31'd0, bus.tx_busy}, 32'd1);
        presetn = 1'b0;
        #1;
        chk("async_reset", {28'd0, bus.txd, bus.tx_busy, bus.tsr_load, bus.shift_cnt_eq}, 32'b1000);
        @(posedge pclk); #1;
        presetn = 1'b1;
        check_idle("idle_after_async_reset");
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
